i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
- Oversampled I2C target (responder) for the same bus driven by the team's I2C master.
- Detects START/STOP, matches a fixed 7-bit address, and ACKs it.
- Write transfers: delivers received bytes to local logic. Read transfers: fetches bytes from local logic and shifts them out.
- SDA is open-drain; the block only ever pulls low. Runs on the system clk, which must be at least 8x the SCL frequency.

Parameters:
- ADDR, 7'h50, own 7-bit target address.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (legal values 2..3).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- scl_in  in  1  bus SCL (sampled, never driven).
- sda_in  in  1  bus SDA level.
- sda_oe  out  1  1 = pull SDA low; 0 = release (high-Z).
- rx_data  out  8  last byte received in a write transfer.
- rx_valid  out  1  one-clk pulse when rx_data is updated.
- tx_data  in  8  byte to send in a read transfer.
- tx_req  out  1  one-clk pulse requesting the next tx_data.
- busy  out  1  high while addressed (address ACKed, until STOP/START).
- bus_err  out  1  one-clk pulse on START/STOP received mid-byte while addressed.

Behaviour:
- Reset: state IDLE, sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, busy=0, bus_err=0, bit counter=0. Reset mid-transfer releases SDA immediately (asynchronous).
- Input path: SYNC_STAGES flops, then a one-flop edge detector. Pin-to-event latency is SYNC_STAGES+1 clks.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Bit sampling: on SCL rising events, MSB first.
- sda_oe changes: only on SCL falling events, plus the asynchronous release on START/STOP/reset.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT.
- START in any state: go to ADDR, bit counter=0, sda_oe=0. If in WR_DATA/RD_DATA with counter!=0, pulse bus_err.
- STOP in any state: go to IDLE, sda_oe=0, busy=0. Same bus_err rule as START.
- ADDR: shift 8 bits. After the 8th rising event:
  - if shift[7:1]==ADDR: go to ADDR_ACK and latch rw=shift[0];
  - otherwise go to WAIT, which ignores everything except START/STOP.
- ADDR_ACK:
  - next SCL fall: sda_oe=1, busy=1; if rw=1, pulse tx_req.
  - following SCL fall: go to WR_DATA (rw=0) or RD_DATA (rw=1).
  - RD_DATA path: tx_data is loaded into the shift register at this same falling event, and sda_oe=~tx_data[7] is driven from that event.
- WR_DATA: shift 8 bits on rising events. On the 8th: rx_data<=shift, rx_valid pulse (same clk as the 8th rising-edge detect +1), go to WR_ACK.
- WR_ACK: always ACK. sda_oe=1 on next fall, released on the fall after that, then back to WR_DATA.
- RD_DATA: drive sda_oe=~bit on each falling event. After the 8th bit's falling event, release (sda_oe=0) and go to RD_ACK.
- RD_ACK: sample SDA on rising event.
  - 0 (master ACK): pulse tx_req; at next fall reload tx_data and go to RD_DATA.
  - 1 (NACK): go to WAIT with SDA released.
- tx_data timing: local logic must present tx_data within 2 clks of tx_req. The value is sampled at the SCL fall that starts the byte.
- Counter: 3-bit, wraps 7->0 at byte end. No ACK is given to a non-matching address. Simultaneous START and STOP detects cannot occur (mutually exclusive SDA edges).

Optional Feature:
- Macro I2C_SLAVE_GEN_CALL_EN.
- Defined: address byte 8'h00 (general call, rw=0) is also ACKed and handled as a write. busy rises as normal; rx_valid bytes are flagged via an extra output gen_call (1 while in a general-call transfer).
- Undefined: 8'h00 is a non-matching address (WAIT); the gen_call port does not exist.

Decomposition:
- Package i2c_pkg:
  - i2c_slave_state_e enum;
  - constants I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_GEN_CALL_ADDR=7'h00.
- Sub-module i2c_bus_sync: synchronizers plus edge detect. Outputs scl_rise, scl_fall, sda_s, start_det, stop_det.

Test Plan:
- START, addr 0x50 W, data 0xA5, STOP -> sda_oe=1 in both ACK slots; rx_data=0xA5 with one rx_valid pulse; busy falls at STOP.
- START, addr 0x51 W -> no ACK (SDA stays high in the 9th slot); no rx_valid or tx_req; busy=0.
- START, 0x50 R, tx_data=0x3C then 0xC3, master ACK then NACK -> bus sees 0x3C then 0xC3; two tx_req pulses; SDA released after NACK.
- Write 0x11, repeated START, read 1 byte -> rx_valid once; rw switches; tx_req once; no bus_err.
- STOP injected after 3 data bits -> bus_err pulse, IDLE, sda_oe=0; next transaction succeeds.
- reset asserted while driving ACK -> sda_oe=0 immediately; all outputs 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the oversampled I2C target.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_WAIT
  } i2c_slave_state_e;

  localparam logic       I2C_ACK           = 1'b0;
  localparam logic       I2C_NACK          = 1'b1;
  localparam logic [6:0] I2C_GEN_CALL_ADDR = 7'h00;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers followed by a one-flop edge detector that flags
// SCL edges and START/STOP conditions.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// Oversampled I2C target with a fixed 7-bit address. Define
// I2C_SLAVE_GEN_CALL_EN to also accept general-call writes (adds gen_call).
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       bus_err
`ifdef I2C_SLAVE_GEN_CALL_EN
  ,
  output logic       gen_call
`endif
);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_s    (sda_s),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  i2c_slave_state_e state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic       rw, rw_n;
  logic       ack_seen, ack_seen_n;
  logic       sda_oe_n, rx_valid_n, tx_req_n, busy_n, bus_err_n;
  logic [7:0] rx_data_n;
  logic [7:0] shift_in;
  logic       mid_byte;
`ifdef I2C_SLAVE_GEN_CALL_EN
  logic       gen_call_n;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      rw       <= 1'b0;
      ack_seen <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
      bus_err  <= 1'b0;
`ifdef I2C_SLAVE_GEN_CALL_EN
      gen_call <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      rw       <= rw_n;
      ack_seen <= ack_seen_n;
      sda_oe   <= sda_oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_req   <= tx_req_n;
      busy     <= busy_n;
      bus_err  <= bus_err_n;
`ifdef I2C_SLAVE_GEN_CALL_EN
      gen_call <= gen_call_n;
`endif
    end
  end

  assign shift_in = {shift[6:0], sda_s};
  // In data states bit_cnt counts completed bits, so the SCL rise that
  // precedes a repeated START is not mistaken for a truncated byte.
  assign mid_byte = ((state == S_WR_DATA) || (state == S_RD_DATA)) && (bit_cnt != 3'd0);

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    rw_n       = rw;
    ack_seen_n = ack_seen;
    sda_oe_n   = sda_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    busy_n     = busy;
    bus_err_n  = 1'b0;
`ifdef I2C_SLAVE_GEN_CALL_EN
    gen_call_n = gen_call;
`endif
    if (start_det || stop_det) begin
      state_n    = start_det ? S_ADDR : S_IDLE;
      bit_cnt_n  = 3'd0;
      sda_oe_n   = 1'b0;
      busy_n     = 1'b0;
      ack_seen_n = 1'b0;
      bus_err_n  = mid_byte;
`ifdef I2C_SLAVE_GEN_CALL_EN
      gen_call_n = 1'b0;
`endif
    end else begin
      case (state)
        S_ADDR: begin
          if (scl_rise) begin
            shift_n   = shift_in;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (shift_in[7:1] == ADDR) begin
                state_n = S_ADDR_ACK;
                rw_n    = shift_in[0];
`ifdef I2C_SLAVE_GEN_CALL_EN
              end else if (shift_in == {I2C_GEN_CALL_ADDR, 1'b0}) begin
                state_n    = S_ADDR_ACK;
                rw_n       = 1'b0;
                gen_call_n = 1'b1;
`endif
              end else begin
                state_n = S_WAIT;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          // First fall drives the ACK; the next one ends the ACK slot.
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = ~I2C_ACK;
              busy_n   = 1'b1;
              tx_req_n = rw;
            end else if (rw) begin
              shift_n   = tx_data;
              sda_oe_n  = ~tx_data[7];
              bit_cnt_n = 3'd0;
              state_n   = S_RD_DATA;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 3'd0;
              state_n   = S_WR_DATA;
            end
          end
        end
        S_WR_DATA: begin
          if (scl_rise) begin
            shift_n = shift_in;
            if (bit_cnt == 3'd7) begin
              rx_data_n  = shift_in;
              rx_valid_n = 1'b1;
              bit_cnt_n  = 3'd0;
              state_n    = S_WR_ACK;
            end
          end else if (scl_fall) begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = ~I2C_ACK;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = S_WR_DATA;
            end
          end
        end
        S_RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_n   = 1'b0;
              bit_cnt_n  = 3'd0;
              ack_seen_n = 1'b0;
              state_n    = S_RD_ACK;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
              shift_n   = {shift[6:0], 1'b0};
              sda_oe_n  = ~shift[6];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              tx_req_n   = 1'b1;
              ack_seen_n = 1'b1;
            end else begin
              state_n = S_WAIT;
            end
          end else if (scl_fall && ack_seen) begin
            shift_n    = tx_data;
            sda_oe_n   = ~tx_data[7];
            ack_seen_n = 1'b0;
            state_n    = S_RD_DATA;
          end
        end
        S_IDLE, S_WAIT: begin
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bus-level master tasks on an open-drain SDA
// model, with scenario tasks checking ACK slots, bytes and output pulses.
module tb_i2c_slave;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic       busy;
  logic       bus_err;

  int errors = 0;
  int checks = 0;
  int rx_valid_cnt = 0;
  int tx_req_cnt = 0;
  int bus_err_cnt = 0;
  int tx_idx = 0;
  logic [7:0] tx_vals [8];

  assign sda_bus = m_sda & ~sda_oe;

  i2c_slave dut (
    .clk     (clk),
    .reset   (reset),
    .scl_in  (m_scl),
    .sda_in  (sda_bus),
    .sda_oe  (sda_oe),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .busy    (busy),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  // Local-logic responder and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_valid_cnt++;
    if (bus_err === 1'b1) bus_err_cnt++;
    if (tx_req === 1'b1) begin
      tx_req_cnt++;
      if (tx_idx < 8) tx_data = tx_vals[tx_idx];
      tx_idx++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    m_sda = 1'b0; wait_clks(Q);
    m_scl = 1'b0; wait_clks(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    m_sda = 1'b1; wait_clks(Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wait_clks(Q);
    m_scl = 1'b1; wait_clks(2 * Q);
    m_scl = 1'b0; wait_clks(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    b = sda_bus;  wait_clks(Q);
    m_scl = 1'b0; wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(master_ack);
  endtask

  task automatic test_reset();
    reset = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    wait_clks(4);
    reset = 1'b0;
    wait_clks(4);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (tx_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_req: got %b expected 0", tx_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_err: got %b expected 0", bus_err); end
  endtask

  task automatic test_write();
    int rv0, be0;
    logic ack;
    rv0 = rx_valid_cnt; be0 = bus_err_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL wr_addr_ack: got %b expected 0", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL wr_busy: got %b expected 1", busy); end
    write_byte(8'hA5, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL wr_data_ack: got %b expected 0", ack); end
    bus_stop();
    wait_clks(8);
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL wr_rx_data: got %h expected a5", rx_data); end
    checks++; if (rx_valid_cnt - rv0 !== 1) begin errors++; $display("[TB] FAIL wr_rx_valid_cnt: got %0d expected 1", rx_valid_cnt - rv0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wr_busy_after_stop: got %b expected 0", busy); end
    checks++; if (bus_err_cnt - be0 !== 0) begin errors++; $display("[TB] FAIL wr_bus_err: got %0d expected 0", bus_err_cnt - be0); end
  endtask

  task automatic test_no_match();
    int rv0, tr0;
    logic ack;
    rv0 = rx_valid_cnt; tr0 = tx_req_cnt;
    bus_start();
    write_byte(8'hA2, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL nm_addr_nack: got %b expected 1", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nm_busy: got %b expected 0", busy); end
    write_byte(8'h55, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL nm_data_nack: got %b expected 1", ack); end
    bus_stop();
    wait_clks(8);
    checks++; if (rx_valid_cnt - rv0 !== 0) begin errors++; $display("[TB] FAIL nm_rx_valid_cnt: got %0d expected 0", rx_valid_cnt - rv0); end
    checks++; if (tx_req_cnt - tr0 !== 0) begin errors++; $display("[TB] FAIL nm_tx_req_cnt: got %0d expected 0", tx_req_cnt - tr0); end
  endtask

  task automatic test_read();
    int tr0, be0;
    logic ack;
    logic [7:0] d;
    tr0 = tx_req_cnt; be0 = bus_err_cnt;
    bus_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL rd_addr_ack: got %b expected 0", ack); end
    read_byte(1'b0, d);
    checks++; if (d !== 8'h3C) begin errors++; $display("[TB] FAIL rd_byte0: got %h expected 3c", d); end
    read_byte(1'b1, d);
    checks++; if (d !== 8'hC3) begin errors++; $display("[TB] FAIL rd_byte1: got %h expected c3", d); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL rd_release_after_nack: got %b expected 0", sda_oe); end
    bus_stop();
    wait_clks(8);
    checks++; if (tx_req_cnt - tr0 !== 2) begin errors++; $display("[TB] FAIL rd_tx_req_cnt: got %0d expected 2", tx_req_cnt - tr0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rd_busy_after_stop: got %b expected 0", busy); end
    checks++; if (bus_err_cnt - be0 !== 0) begin errors++; $display("[TB] FAIL rd_bus_err: got %0d expected 0", bus_err_cnt - be0); end
  endtask

  task automatic test_back_to_back();
    int rv0, tr0, be0;
    logic ack;
    logic [7:0] d;
    rv0 = rx_valid_cnt; tr0 = tx_req_cnt; be0 = bus_err_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h11, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL b2b_wr_ack: got %b expected 0", ack); end
    bus_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rd_addr_ack: got %b expected 0", ack); end
    read_byte(1'b1, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("[TB] FAIL b2b_rd_byte: got %h expected 5a", d); end
    bus_stop();
    wait_clks(8);
    checks++; if (rx_data !== 8'h11) begin errors++; $display("[TB] FAIL b2b_rx_data: got %h expected 11", rx_data); end
    checks++; if (rx_valid_cnt - rv0 !== 1) begin errors++; $display("[TB] FAIL b2b_rx_valid_cnt: got %0d expected 1", rx_valid_cnt - rv0); end
    checks++; if (tx_req_cnt - tr0 !== 1) begin errors++; $display("[TB] FAIL b2b_tx_req_cnt: got %0d expected 1", tx_req_cnt - tr0); end
    checks++; if (bus_err_cnt - be0 !== 0) begin errors++; $display("[TB] FAIL b2b_bus_err: got %0d expected 0", bus_err_cnt - be0); end
  endtask

  task automatic test_bus_err();
    int rv0, be0;
    logic ack;
    rv0 = rx_valid_cnt; be0 = bus_err_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    bus_stop();
    wait_clks(8);
    checks++; if (bus_err_cnt - be0 !== 1) begin errors++; $display("[TB] FAIL be_pulse_cnt: got %0d expected 1", bus_err_cnt - be0); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL be_sda_oe: got %b expected 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL be_busy: got %b expected 0", busy); end
    checks++; if (rx_valid_cnt - rv0 !== 0) begin errors++; $display("[TB] FAIL be_rx_valid_cnt: got %0d expected 0", rx_valid_cnt - rv0); end
    bus_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL be_recover_addr_ack: got %b expected 0", ack); end
    write_byte(8'h7E, ack);
    bus_stop();
    wait_clks(8);
    checks++; if (rx_data !== 8'h7E) begin errors++; $display("[TB] FAIL be_recover_rx_data: got %h expected 7e", rx_data); end
    checks++; if (rx_valid_cnt - rv0 !== 1) begin errors++; $display("[TB] FAIL be_recover_rx_valid: got %0d expected 1", rx_valid_cnt - rv0); end
  endtask

  task automatic test_reset_mid_ack();
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 5);
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("[TB] FAIL rst_ack_driven: got %b expected 1", sda_oe); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_busy_before: got %b expected 1", busy); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_sda_oe: got %b expected 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_busy: got %b expected 0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_async_rx_data: got %h expected 00", rx_data); end
    m_scl = 1'b1; m_sda = 1'b1;
    wait_clks(4);
    reset = 1'b0;
    wait_clks(8);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL rst_after_sda_oe: got %b expected 0", sda_oe); end
    checks++; if ({rx_valid, tx_req, bus_err} !== 3'b000) begin errors++; $display("[TB] FAIL rst_after_pulses: got %b expected 000", {rx_valid, tx_req, bus_err}); end
  endtask

  initial begin
    tx_vals[0] = 8'h3C; tx_vals[1] = 8'hC3; tx_vals[2] = 8'h5A; tx_vals[3] = 8'h00;
    tx_vals[4] = 8'h00; tx_vals[5] = 8'h00; tx_vals[6] = 8'h00; tx_vals[7] = 8'h00;
    test_reset();
    test_write();
    test_no_match();
    test_read();
    test_back_to_back();
    test_bus_err();
    test_reset_mid_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
